// File: rtl/sd_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sd_fifo_pkg
// Shared definitions for the SD data FIFO slice:
//   - default parameter constants for sd_data_fifo
//   - sd_fifo_status_t, a packed view of the four status flags
//   - byte_parity(), the even-parity bit for one byte
// Optional feature macro used by the FIFO: SD_FIFO_PARITY_EN
// ---------------------------------------------------------------------------
package sd_fifo_pkg;

   localparam int DEF_DATA_W    = 32;
   localparam int DEF_DEPTH     = 512;
   localparam int DEF_AEMPTY_TH = 8;

   typedef struct packed {
      logic full;
      logic almost_full;
      logic empty;
      logic almost_empty;
   } sd_fifo_status_t;

   // Even parity: the returned bit makes the total count of ones in
   // {byte, parity} even.
   function automatic logic byte_parity(input logic [7:0] data_byte);
      return ^data_byte;
   endfunction

endpackage

// File: rtl/sd_fifo_ram.sv
// ---------------------------------------------------------------------------
// sd_fifo_ram
// Storage array for sd_data_fifo. Synchronous write, asynchronous read, so
// the FIFO head is visible combinationally (first-word fall-through).
// The array is never cleared; only the FIFO pointers are reset.
// Ports:
//   aclk   - clock, write on rising edge
//   we     - write enable
//   waddr  - write address
//   wdata  - write data (WIDTH bits)
//   raddr  - read address
//   rdata  - read data (WIDTH bits), combinational from raddr
// ---------------------------------------------------------------------------
module sd_fifo_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 512
) (
   input  logic                     aclk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Plain write port with no reset so the array maps onto RAM primitives.
   always_ff @(posedge aclk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sd_data_fifo.sv
// ---------------------------------------------------------------------------
// sd_data_fifo
// Single-clock first-word-fall-through FIFO for SD card data.
// Optional per-byte even parity is enabled by defining SD_FIFO_PARITY_EN;
// without it par_inject is ignored and par_err is held low.
// Ports:
//   aclk, aresetn        - clock, asynchronous active-low reset
//   flush                - synchronous clear of both pointers
//   wr_en, wr_data       - write request and data
//   par_inject           - on a write, flips the stored parity of byte 0
//   rd_en, rd_data       - pop request and head-of-FIFO data
//   full, almost_full    - status flags (almost_full: count >= AFULL_TH)
//   empty, almost_empty  - status flags (almost_empty: count <= AEMPTY_TH)
//   count                - registered occupancy
//   wr_err, rd_err       - one-cycle overflow / underflow pulses
//   par_err              - one-cycle parity mismatch pulse after a pop
// ---------------------------------------------------------------------------
module sd_data_fifo
   import sd_fifo_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AFULL_TH  = DEPTH - 8,
   parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     flush,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     par_inject,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     full,
   output logic                     almost_full,
   output logic                     empty,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     wr_err,
   output logic                     rd_err,
   output logic                     par_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
`ifdef SD_FIFO_PARITY_EN
   localparam int NB    = DATA_W / 8;
   localparam int MEM_W = DATA_W + NB;
`else
   localparam int MEM_W = DATA_W;
`endif

   logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
   logic [PW-1:0]    count_q;
   logic             afull_q, aempty_q;
   logic             wr_err_q, rd_err_q;
   logic             wr_fire, rd_fire;
   logic [MEM_W-1:0] mem_wdata, mem_rdata;
   sd_fifo_status_t  status;

   // Full and empty come straight from the registered pointers; the extra
   // MSB distinguishes a wrapped (full) pointer pair from an equal (empty) one.
   assign status.full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                                (wr_ptr[AW] != rd_ptr[AW]);
   assign status.empty        = (wr_ptr == rd_ptr);
   assign status.almost_full  = afull_q;
   assign status.almost_empty = aempty_q;

   assign full         = status.full;
   assign almost_full  = status.almost_full;
   assign empty        = status.empty;
   assign almost_empty = status.almost_empty;
   assign count        = count_q;
   assign wr_err       = wr_err_q;
   assign rd_err       = rd_err_q;
   assign rd_data      = mem_rdata[DATA_W-1:0];

   // A write into a full FIFO is allowed when a pop frees the head slot in
   // the same cycle. A read on an empty FIFO never bypasses a concurrent
   // write. Flush overrides both requests.
   always_comb begin
      wr_fire    = wr_en && (!status.full || rd_en) && !flush;
      rd_fire    = rd_en && !status.empty && !flush;
      wr_ptr_nxt = flush ? '0 : wr_ptr + PW'(wr_fire);
      rd_ptr_nxt = flush ? '0 : rd_ptr + PW'(rd_fire);
      count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
   end

   // Pointers, occupancy and threshold flags all update on the same edge;
   // the error pulses last exactly one cycle.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         wr_err_q <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr_nxt;
         rd_ptr   <= rd_ptr_nxt;
         count_q  <= count_nxt;
         afull_q  <= (count_nxt >= PW'(AFULL_TH));
         aempty_q <= (count_nxt <= PW'(AEMPTY_TH));
         wr_err_q <= wr_en && status.full && !rd_en && !flush;
         rd_err_q <= rd_en && status.empty && !flush;
      end
   end

`ifdef SD_FIFO_PARITY_EN
   logic [NB-1:0] wr_par, rd_par_calc;
   logic          par_err_q;

   // Parity is generated per byte on the way in and recomputed over the
   // head word on the way out; par_inject corrupts byte 0 for fault tests.
   always_comb begin
      wr_par      = '0;
      rd_par_calc = '0;
      for (int b = 0; b < NB; b++) begin
         wr_par[b]      = byte_parity(wr_data[8*b +: 8]);
         rd_par_calc[b] = byte_parity(mem_rdata[8*b +: 8]);
      end
      wr_par[0] = wr_par[0] ^ par_inject;
   end

   assign mem_wdata = {wr_par, wr_data};

   // The mismatch is registered so it appears in the cycle after the pop.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         par_err_q <= 1'b0;
      end else begin
         par_err_q <= rd_fire && (rd_par_calc != mem_rdata[MEM_W-1 -: NB]);
      end
   end

   assign par_err = par_err_q;
`else
   logic unused_par_inject;

   assign unused_par_inject = par_inject;
   assign mem_wdata         = wr_data;
   assign par_err           = 1'b0;
`endif

   sd_fifo_ram #(
      .WIDTH (MEM_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .aclk  (aclk),
      .we    (wr_fire),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (mem_wdata),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_sd_data_fifo.sv
// ---------------------------------------------------------------------------
// tb_sd_data_fifo
// Directed bench for sd_data_fifo with DEPTH=16, AFULL_TH=14, AEMPTY_TH=2.
// A queue holds the words the FIFO should contain; its size is the expected
// occupancy and its head the expected rd_data.
// ---------------------------------------------------------------------------
module tb_sd_data_fifo;

   localparam int DATA_W    = 32;
   localparam int DEPTH     = 16;
   localparam int AFULL_TH  = 14;
   localparam int AEMPTY_TH = 2;
   localparam int CW        = $clog2(DEPTH) + 1;
`ifdef SD_FIFO_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic              aclk = 1'b0;
   logic              aresetn;
   logic              flush;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              par_inject;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              full, almost_full, empty, almost_empty;
   logic [CW-1:0]     count;
   logic              wr_err, rd_err, par_err;

   int                checks = 0;
   int                errors = 0;
   logic [DATA_W-1:0] sb[$];
   logic              pq[$];

   sd_data_fifo #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .AFULL_TH  (AFULL_TH),
      .AEMPTY_TH (AEMPTY_TH)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .flush        (flush),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .par_inject   (par_inject),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .full         (full),
      .almost_full  (almost_full),
      .empty        (empty),
      .almost_empty (almost_empty),
      .count        (count),
      .wr_err       (wr_err),
      .rd_err       (rd_err),
      .par_err      (par_err)
   );

   always #5 aclk = ~aclk;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [DATA_W-1:0] obs,
                               input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compares every status output against the queue-based expectation.
   task automatic check_flags(input logic exp_wr_err, input logic exp_rd_err,
                              input logic exp_par_err);
      int n;
      n = sb.size();
      check_output("count", 32'(count), 32'(n));
      check_output("full", 32'(full), 32'(n == DEPTH));
      check_output("empty", 32'(empty), 32'(n == 0));
      check_output("almost_full", 32'(almost_full), 32'(n >= AFULL_TH));
      check_output("almost_empty", 32'(almost_empty), 32'(n <= AEMPTY_TH));
      check_output("wr_err", 32'(wr_err), 32'(exp_wr_err));
      check_output("rd_err", 32'(rd_err), 32'(exp_rd_err));
      check_output("par_err", 32'(par_err), 32'(exp_par_err));
      if (n > 0) begin
         check_output("head", rd_data, sb[0]);
      end
   endtask

   // Drives one cycle of requests, predicts its effect, then checks after
   // the edge.
   task automatic apply_stimulus(input logic we, input logic [DATA_W-1:0] wd,
                                 input logic re, input logic fl, input logic pi);
      int   n;
      logic exp_full, exp_empty, rd_acc, wr_acc;
      logic exp_wr_err, exp_rd_err, exp_par, popped_pi;
      wr_en      = we;
      wr_data    = wd;
      rd_en      = re;
      flush      = fl;
      par_inject = pi;
      n          = sb.size();
      exp_full   = (n == DEPTH);
      exp_empty  = (n == 0);
      rd_acc     = re && !exp_empty && !fl;
      wr_acc     = we && (!exp_full || re) && !fl;
      exp_wr_err = we && exp_full && !re && !fl;
      exp_rd_err = re && exp_empty && !fl;
      popped_pi  = 1'b0;
      if (rd_acc) begin
         check_output("pop_data", rd_data, sb.pop_front());
         popped_pi = pq.pop_front();
      end
      if (fl) begin
         sb.delete();
         pq.delete();
      end
      if (wr_acc) begin
         sb.push_back(wd);
         pq.push_back(pi);
      end
      exp_par = PAR_EN && rd_acc && popped_pi;
      @(posedge aclk);
      #1;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      flush      = 1'b0;
      par_inject = 1'b0;
      check_flags(exp_wr_err, exp_rd_err, exp_par);
   endtask

   initial begin
      aresetn    = 1'b0;
      flush      = 1'b0;
      wr_en      = 1'b0;
      wr_data    = '0;
      par_inject = 1'b0;
      rd_en      = 1'b0;

      $display("[TB] reset values");
      repeat (2) @(posedge aclk);
      #1;
      check_flags(1'b0, 1'b0, 1'b0);

      $display("[TB] read at reset release, then write-to-read latency");
      aresetn = 1'b1;
      apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

      $display("[TB] fill to full");
      for (int i = 1; i <= DEPTH; i++) begin
         apply_stimulus(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
      end

      $display("[TB] overflow, then write and read together while full");
      apply_stimulus(1'b1, 32'h0BAD0BAD, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 32'h00000100, 1'b1, 1'b0, 1'b0);

      $display("[TB] drain");
      for (int i = 0; i < DEPTH; i++) begin
         apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

      $display("[TB] write and read together while empty");
      apply_stimulus(1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

      $display("[TB] flush overrides a write");
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(1'b1, 32'hC0DE0000 + 32'(i), 1'b0, 1'b0, 1'b0);
      end
      apply_stimulus(1'b1, 32'h0000F00D, 1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

      $display("[TB] parity injection");
      apply_stimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b1, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

      $display("[TB] reset mid-burst");
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b1, 32'h55550000 + 32'(i), 1'b0, 1'b0, 1'b0);
      end
      aresetn = 1'b0;
      #2;
      sb.delete();
      pq.delete();
      check_flags(1'b0, 1'b0, 1'b0);
      #2;
      aresetn = 1'b1;
      apply_stimulus(1'b1, 32'h00000077, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 32'h00000078, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
